// File: rtl/rv32i_mem_responder.sv
// rv32i_mem_responder
//   Memory-side responder for the pipelined rv32i core. One unified word RAM
//   serves both the instruction fetch port and the data load/store port, and
//   a 16-byte MMIO window holds the LED register, a 64-bit cycle counter and
//   a sticky error status register. After reset a boot loader fills the RAM
//   from a streaming port and holds the core disabled until the final word.
//
//   Parameters
//     MEM_WORDS      RAM depth in 32-bit words
//     MMIO_BASE      byte address of the MMIO window (16-byte aligned)
//     CYCLE_RST_VAL  cycle counter value after reset (0 in normal use; lets a
//                    bench reach the 32-bit carry without billions of cycles)
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     instr_mem_addr      fetch byte address     -> instr_mem_rd_data (comb)
//     data_mem_addr       load/store byte address -> data_mem_rd_data (comb)
//     data_mem_wr_data    store data, committed on the edge when data_mem_wr_ena
//     load_valid/data/last/ready   boot image stream
//     core_ena            high only once the image is loaded
//     leds                LED register bits [7:0]
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_LOAD | boot stream fills RAM[ptr]; core held off; core ports inert
//   ST_RUN  | core running; RAM and MMIO visible; terminal until rst
//
//   MMIO map (offset from MMIO_BASE)
//     0x0 LED   RW   0x4 CYCLO RO (write clears 64 bits)
//     0x8 CYCHI RO   0xC STAT  W1C {load_ovf, range, misaligned}

module rv32i_mem_responder #(
   parameter int unsigned MEM_WORDS     = 1024,
   parameter logic [31:0] MMIO_BASE     = 32'hFFFF_F000,
   parameter logic [63:0] CYCLE_RST_VAL = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_mem_addr,
   output logic [31:0] instr_mem_rd_data,
   input  logic [31:0] data_mem_addr,
   input  logic [31:0] data_mem_wr_data,
   input  logic        data_mem_wr_ena,
   output logic [31:0] data_mem_rd_data,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        core_ena,
   output logic [7:0]  leds
);

   localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int unsigned PTR_W = $clog2(MEM_WORDS + 1);
   localparam logic [29:0] MEM_WORDS_30 = 30'(MEM_WORDS);
   localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(MEM_WORDS);
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [7:0]        led_q, led_d;
   logic [63:0]       cycle_q, cycle_d;
   logic [2:0]        stat_q, stat_d;
   logic              core_ena_q, core_ena_d;
   logic              load_ready_q, load_ready_d;

   logic [2:0]        stat_set, stat_clr;
   logic              ram_we;
   logic [IDX_W-1:0]  ram_widx;
   logic [31:0]       ram_wdata;

   logic [31:0]       ram [MEM_WORDS];

   logic              instr_in_ram, data_in_ram, mmio_hit;
   logic [IDX_W-1:0]  instr_idx, data_idx;
   logic [31:0]       mmio_off, mmio_rd_data;
   logic              unused_bits;

   assign instr_in_ram = instr_mem_addr[31:2] < MEM_WORDS_30;
   assign data_in_ram  = data_mem_addr[31:2] < MEM_WORDS_30;
   assign instr_idx    = instr_mem_addr[IDX_W+1:2];
   assign data_idx     = data_mem_addr[IDX_W+1:2];

   // Subtract-then-compare keeps the window check correct for any base.
   assign mmio_off = data_mem_addr - MMIO_BASE;
   assign mmio_hit = (data_mem_addr >= MMIO_BASE) && (mmio_off < 32'd16);

   // Fetches are word-granular, so the byte offset is deliberately dropped.
   assign unused_bits = ^instr_mem_addr[1:0];

   always_comb begin
      mmio_rd_data = 32'h0;
      case (mmio_off[3:2])
         2'd0:    mmio_rd_data = {24'h0, led_q};
         2'd1:    mmio_rd_data = cycle_q[31:0];
         2'd2:    mmio_rd_data = cycle_q[63:32];
         default: mmio_rd_data = {29'h0, stat_q};
      endcase
   end

   always_comb begin
      instr_mem_rd_data = NOP_INSTR;
      if (state_q == ST_RUN && instr_in_ram) begin
         instr_mem_rd_data = ram[instr_idx];
      end
   end

   always_comb begin
      data_mem_rd_data = 32'h0;
      if (state_q == ST_RUN) begin
         if (data_in_ram) begin
            data_mem_rd_data = ram[data_idx];
         end else if (mmio_hit) begin
            data_mem_rd_data = mmio_rd_data;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      led_d     = led_q;
      cycle_d   = cycle_q;
      stat_set  = 3'b000;
      stat_clr  = 3'b000;
      ram_we    = 1'b0;
      ram_widx  = data_idx;
      ram_wdata = data_mem_wr_data;

      case (state_q)
         ST_LOAD: begin
            if (load_valid && load_ready_q) begin
               // Once full, words are dropped but the last flag still
               // releases the core so a too-large image cannot hang boot.
               if (ptr_q != PTR_FULL) begin
                  ram_we    = 1'b1;
                  ram_widx  = ptr_q[IDX_W-1:0];
                  ram_wdata = load_data;
                  ptr_d     = ptr_q + PTR_W'(1);
               end else begin
                  stat_set[2] = 1'b1;
               end
               if (load_last) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: begin
            cycle_d = cycle_q + 64'd1;
            if (data_mem_wr_ena) begin
               if (data_mem_addr[1:0] != 2'b00) begin
                  stat_set[0] = 1'b1;
               end else if (data_in_ram) begin
                  ram_we = 1'b1;
               end else if (mmio_hit) begin
                  case (mmio_off[3:2])
                     2'd0:    led_d = data_mem_wr_data[7:0];
                     2'd1:    cycle_d = 64'h0;
                     2'd2:    ;
                     default: stat_clr = data_mem_wr_data[2:0];
                  endcase
               end else begin
                  stat_set[1] = 1'b1;
               end
            end
         end
      endcase

      // Set after clear: an error in the same cycle as its W1C survives.
      stat_d       = (stat_q & ~stat_clr) | stat_set;
      core_ena_d   = (state_d == ST_RUN);
      load_ready_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         ptr_q        <= '0;
         led_q        <= 8'h0;
         cycle_q      <= CYCLE_RST_VAL;
         stat_q       <= 3'b000;
         core_ena_q   <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         led_q        <= led_d;
         cycle_q      <= cycle_d;
         stat_q       <= stat_d;
         core_ena_q   <= core_ena_d;
         load_ready_q <= load_ready_d;
      end
   end

   // RAM contents survive reset; only the write strobe is gated by it.
   always_ff @(posedge clk) begin
      if (ram_we && !rst) begin
         ram[ram_widx] <= ram_wdata;
      end
   end

   assign core_ena   = core_ena_q;
   assign load_ready = load_ready_q;
   assign leds       = led_q;

endmodule

// File: tb/tb_rv32i_mem_responder.sv
module tb_rv32i_mem_responder;

   localparam int unsigned MEM       = 1024;
   localparam logic [31:0] MEM_W     = 32'd1024;
   localparam logic [31:0] BASE      = 32'hFFFF_F000;
   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [63:0] WRAP_INIT = 64'h0000_0000_FFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_addr, i_rd, d_addr, d_wdata, d_rd, load_data;
   logic        d_wr_ena, load_valid, load_last, load_ready, core_ena;
   logic [7:0]  leds;

   logic [31:0] w_addr, w_i_rd, w_d_rd;
   logic        w_load_valid, w_load_last, w_load_ready, w_core_ena;
   logic [7:0]  w_leds;

   always #5 clk = ~clk;

   rv32i_mem_responder #(.MEM_WORDS(MEM), .MMIO_BASE(BASE)) dut (
      .clk(clk), .rst(rst),
      .instr_mem_addr(i_addr), .instr_mem_rd_data(i_rd),
      .data_mem_addr(d_addr), .data_mem_wr_data(d_wdata),
      .data_mem_wr_ena(d_wr_ena), .data_mem_rd_data(d_rd),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready), .core_ena(core_ena), .leds(leds)
   );

   // Second instance starts its counter just below the 32-bit carry.
   rv32i_mem_responder #(.MEM_WORDS(MEM), .MMIO_BASE(BASE),
                         .CYCLE_RST_VAL(WRAP_INIT)) u_wrap (
      .clk(clk), .rst(rst),
      .instr_mem_addr(32'h0), .instr_mem_rd_data(w_i_rd),
      .data_mem_addr(w_addr), .data_mem_wr_data(32'h0),
      .data_mem_wr_ena(1'b0), .data_mem_rd_data(w_d_rd),
      .load_valid(w_load_valid), .load_data(32'h0), .load_last(w_load_last),
      .load_ready(w_load_ready), .core_ena(w_core_ena), .leds(w_leds)
   );

   // ---------------- reference model ----------------
   bit          m_run;
   int unsigned m_ptr;
   logic [31:0] m_mem [MEM];
   bit          m_vld [MEM];
   logic [7:0]  m_led;
   logic [63:0] m_cyc;
   logic [2:0]  m_stat;
   bit          w_run;
   logic [63:0] w_cyc;

   function automatic bit m_instr_exp(input logic [31:0] a, output logic [31:0] v);
      int idx;
      v = NOP;
      if (!m_run) return 1'b1;
      if ((a >> 2) < MEM_W) begin
         idx = int'(a >> 2);
         v = m_mem[idx];
         return m_vld[idx];
      end
      return 1'b1;
   endfunction

   function automatic bit m_data_exp(input logic [31:0] a, output logic [31:0] v);
      int idx;
      v = 32'h0;
      if (!m_run) return 1'b1;
      if ((a >> 2) < MEM_W) begin
         idx = int'(a >> 2);
         v = m_mem[idx];
         return m_vld[idx];
      end
      if (a >= BASE && (a - BASE) < 32'd16) begin
         case ((a - BASE) >> 2)
            0:       v = {24'h0, m_led};
            1:       v = m_cyc[31:0];
            2:       v = m_cyc[63:32];
            default: v = {29'h0, m_stat};
         endcase
      end
      return 1'b1;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic push(input int k, input logic [31:0] v, input string nm);
      exp_t e;
      e.kind = k;
      e.val  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            0:       act = i_rd;
            1:       act = d_rd;
            2:       act = {31'h0, core_ena};
            3:       act = {31'h0, load_ready};
            4:       act = {24'h0, leds};
            5:       act = w_d_rd;
            default: act = {31'h0, w_core_ena};
         endcase
         n_checks++;
         if (act !== e.val) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", e.name, act, e.val);
         end
      end
   end

   task automatic check_ports(input string tag);
      logic [31:0] v;
      if (m_instr_exp(i_addr, v)) push(0, v, {tag, "_instr"});
      if (m_data_exp(d_addr, v))  push(1, v, {tag, "_data"});
      push(2, {31'h0, m_run}, {tag, "_core_ena"});
      push(3, {31'h0, !m_run}, {tag, "_load_ready"});
      push(4, {24'h0, m_led}, {tag, "_leds"});
      if (!w_run)                   v = 32'h0;
      else if (w_addr == BASE + 4)  v = w_cyc[31:0];
      else                          v = w_cyc[63:32];
      push(5, v, {tag, "_wrap_cyc"});
      push(6, {31'h0, w_run}, {tag, "_wrap_ena"});
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic tick();
      logic [63:0] nxt;
      if (rst) begin
         m_run = 0; m_ptr = 0; m_led = 8'h0; m_cyc = 64'h0; m_stat = 3'b0;
         w_run = 0; w_cyc = WRAP_INIT;
      end else begin
         if (!m_run) begin
            if (load_valid) begin
               if (m_ptr < MEM) begin
                  m_mem[m_ptr] = load_data;
                  m_vld[m_ptr] = 1'b1;
                  m_ptr++;
               end else begin
                  m_stat[2] = 1'b1;
               end
               if (load_last) m_run = 1;
            end
         end else begin
            nxt = m_cyc + 64'd1;
            if (d_wr_ena) begin
               if (d_addr % 4 != 0) begin
                  m_stat[0] = 1'b1;
               end else if ((d_addr >> 2) < MEM_W) begin
                  m_mem[int'(d_addr >> 2)] = d_wdata;
                  m_vld[int'(d_addr >> 2)] = 1'b1;
               end else if (d_addr >= BASE && (d_addr - BASE) < 32'd16) begin
                  case ((d_addr - BASE) >> 2)
                     0:       m_led = d_wdata[7:0];
                     1:       nxt = 64'h0;
                     3:       m_stat = m_stat & ~d_wdata[2:0];
                     default: ;
                  endcase
               end else begin
                  m_stat[1] = 1'b1;
               end
            end
            m_cyc = nxt;
         end
         if (w_run) w_cyc = w_cyc + 64'd1;
         else if (w_load_valid && w_load_last) w_run = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag);
      check_ports(tag);
      tick();
   endtask

   task automatic idle();
      d_wr_ena = 0; load_valid = 0; load_last = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      logic [31:0] abc [3];
      int          r;
      abc[0] = 32'hA0A0_0001; abc[1] = 32'hB0B0_0002; abc[2] = 32'hC0C0_0003;
      rst = 1; idle();
      i_addr = 0; d_addr = 0; d_wdata = 0; load_data = 0;
      w_addr = BASE + 4; w_load_valid = 0; w_load_last = 0;
      for (int i = 0; i < int'(MEM); i++) m_vld[i] = 1'b0;
      tick(); tick();
      rst = 0;
      cyc("reset");

      // three-word image
      for (int i = 0; i < 3; i++) begin
         load_valid = 1; load_data = abc[i]; load_last = (i == 2);
         cyc("load3");
      end
      idle();
      cyc("run_entry");
      for (int i = 0; i < 3; i++) begin
         i_addr = 32'(i * 4); d_addr = 32'(i * 4);
         cyc("abc_rd");
      end

      // reload, with a reset partway through the stream
      rst = 1; tick(); rst = 0;
      for (int i = 0; i < 5; i++) begin
         load_valid = 1; load_data = $urandom;
         cyc("load_pre");
      end
      rst = 1; load_valid = 1; load_data = $urandom; tick();
      rst = 0; load_valid = 0;
      cyc("mid_rst");
      for (int i = 0; i < 24; i++) begin
         load_valid = 1; load_data = $urandom; load_last = (i == 23);
         cyc("load24");
      end
      idle(); i_addr = 0; d_addr = 0;
      cyc("reload_rd");

      // store with read-during-write
      d_addr = 32'h10; i_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_wr_ena = 1;
      cyc("sw_same");
      d_wr_ena = 0;
      cyc("sw_next");

      // error status
      d_addr = 32'h13; d_wdata = 32'h1234_5678; d_wr_ena = 1; cyc("sw_mis");
      d_wr_ena = 0; d_addr = 32'h10;                         cyc("mis_ram");
      d_addr = BASE + 12;                                     cyc("stat_mis");
      d_wdata = 32'h1; d_wr_ena = 1;                          cyc("stat_w1c");
      d_wr_ena = 0;                                           cyc("stat_clr");
      d_addr = 32'h0010_0000; d_wdata = 32'h55; d_wr_ena = 1; cyc("sw_range");
      d_wr_ena = 0; d_addr = BASE + 12;                       cyc("stat_range");
      d_wdata = 32'h2; d_wr_ena = 1;                          cyc("stat_w1c2");
      d_wr_ena = 0;                                           cyc("stat_clr2");

      // LED and cycle counter
      d_addr = BASE; d_wdata = 32'h1A5; d_wr_ena = 1; cyc("led_w");
      d_wr_ena = 0;                                   cyc("led_rd");
      d_addr = BASE + 4;
      repeat (3) cyc("cyclo");
      d_wdata = $urandom; d_wr_ena = 1;               cyc("cyclo_clr");
      d_wr_ena = 0;                                   cyc("cyclo_zero");
      cyc("cyclo_inc");
      d_addr = BASE + 8; d_wdata = 32'hFFFF; d_wr_ena = 1; cyc("cychi_w");
      d_wr_ena = 0;                                        cyc("cychi");

      // out-of-range fetch, and the 32-bit carry on the second instance
      i_addr = 32'h0010_0000; cyc("fetch_oor");
      w_load_valid = 1; w_load_last = 1; cyc("wrap_go");
      w_load_valid = 0; w_load_last = 0;
      for (int i = 0; i < 12; i++) begin
         w_addr = (i % 2 == 1) ? BASE + 8 : BASE + 4;
         cyc("wrap");
      end

      // randomized traffic
      repeat (400) begin
         r = $urandom_range(0, 9);
         if (r <= 3)      d_addr = 32'($urandom_range(0, 31)) * 4;
         else if (r == 4) d_addr = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
         else if (r == 5) d_addr = 32'h0010_0000 + 32'($urandom_range(0, 255)) * 4;
         else if (r <= 8) d_addr = BASE + 32'($urandom_range(0, 3)) * 4;
         else             d_addr = $urandom;
         d_wdata  = $urandom;
         d_wr_ena = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) i_addr = 32'h0010_0000 + 32'($urandom_range(0, 63)) * 4;
         else i_addr = 32'($urandom_range(0, 40)) * 4 + 32'($urandom_range(0, 3));
         cyc("rand");
      end
      idle();

      // oversize image
      rst = 1; tick(); rst = 0;
      i_addr = 0; d_addr = 0;
      for (int i = 0; i < int'(MEM) + 2; i++) begin
         load_valid = 1; load_data = $urandom; load_last = (i == int'(MEM) + 1);
         cyc("ovf_load");
      end
      idle();
      d_addr = 4 * (MEM_W - 1); i_addr = 4 * (MEM_W - 2); cyc("ovf_ram");
      d_addr = BASE + 12; i_addr = 0;                     cyc("ovf_stat");

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
